// File: rtl/sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// sb_tx_arbiter
//
// Sideband TX scheduler that sits in front of the packet framer. NUM_REQ
// message sources share one serializer. A round-robin arbiter picks one of
// them, latches that source's header and data, and issues one framing request
// per packet. The block then follows the serializer's phase-completion pulses
// and inserts an idle gap before the next grant. A watchdog drops a packet if
// the serializer stalls.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   GAP_CYCLES   idle cycles after the last phase before the next grant
//                (0 still gives a single GAP cycle)
//   SER_TIMEOUT  maximum cycles to wait for one i_ser_done pulse (8-bit)
//
// Ports
//   i_clk           sideband TX clock
//   i_rst           asynchronous, active-high reset
//   i_req           per-requester request level, held until granted
//   i_req_header    packed 62-bit headers, requester k at [62k+61:62k]
//   i_req_data      packed 64-bit data, requester k at [64k+63:64k]
//   i_req_has_data  per-requester flag: packet carries a data phase
//   o_grant         one-hot, one-cycle pulse: fields latched, req may drop
//   o_header        latched header to the framer
//   o_data          latched data to the framer (0 for header-only packets)
//   o_header_valid  one-cycle framing request
//   o_data_valid    one-cycle, alongside o_header_valid when data present
//   i_ser_done      one-cycle pulse: serializer finished one 64-bit phase
//   o_busy          high whenever the FSM is not IDLE
//   o_ser_timeout   one-cycle pulse when the serializer watchdog expires
// ---------------------------------------------------------------------------
module sb_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int GAP_CYCLES  = 4,
  parameter int SER_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ*62-1:0] i_req_header,
  input  logic [NUM_REQ*64-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]    i_req_has_data,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [61:0]           o_header,
  output logic [63:0]           o_data,
  output logic                  o_header_valid,
  output logic                  o_data_valid,
  input  logic                  i_ser_done,
  output logic                  o_busy,
  output logic                  o_ser_timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // GAP lasts GAP_CYCLES cycles, but never less than one cycle.
  localparam logic [GW-1:0] GAP_LIM = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // The watchdog counter starts at 0 on WAIT entry, so the last legal wait
  // cycle is the one where the count equals SER_TIMEOUT-1.
  localparam logic [7:0]    WD_LIM  = 8'((SER_TIMEOUT > 0) ? SER_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_HDR,
    WAIT_DATA,
    GAP
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      winner;
  logic               found;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [61:0]        sel_header;
  logic [63:0]        sel_data;
  logic               sel_has_data;

  logic               has_data_q;
  logic [7:0]         wd_cnt;
  logic [GW-1:0]      gap_cnt;

  logic               load_en;
  logic               wd_clear;
  logic               wd_inc;
  logic               timeout_ev;

  logic [NUM_REQ-1:0] grant_q;
  logic [61:0]        header_q;
  logic [63:0]        data_q;
  logic               hv_q;
  logic               dv_q;
  logic               timeout_q;

  // Round-robin search: first asserted request at or after the pointer,
  // wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req[(int'(ptr) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = PW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign ptr_next     = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  assign sel_header   = i_req_header[62*winner +: 62];
  assign sel_data     = i_req_data[64*winner +: 64];
  assign sel_has_data = i_req_has_data[winner];

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the strobes that steer the datapath registers.
  // A serializer completion in the same cycle as watchdog expiry counts as
  // completion, so a slow but successful phase is never dropped.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    wd_clear   = 1'b0;
    wd_inc     = 1'b0;
    timeout_ev = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load_en    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        wd_clear   = 1'b1;
        state_next = WAIT_HDR;
      end
      WAIT_HDR: begin
        if (i_ser_done) begin
          wd_clear   = 1'b1;
          state_next = has_data_q ? WAIT_DATA : GAP;
        end else if (wd_cnt >= WD_LIM) begin
          timeout_ev = 1'b1;
          state_next = GAP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (i_ser_done) begin
          wd_clear   = 1'b1;
          state_next = GAP;
        end else if (wd_cnt >= WD_LIM) begin
          timeout_ev = 1'b1;
          state_next = GAP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LIM) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the winner on grant, pulse the framing request out of
  // LOAD, and run the watchdog and gap counters. All outputs except o_busy
  // are registered so the framer sees clean one-cycle pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr        <= '0;
      grant_q    <= '0;
      header_q   <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
      hv_q       <= 1'b0;
      dv_q       <= 1'b0;
      timeout_q  <= 1'b0;
      wd_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      grant_q   <= '0;
      hv_q      <= 1'b0;
      dv_q      <= 1'b0;
      timeout_q <= timeout_ev;

      if (load_en) begin
        grant_q    <= grant_onehot;
        header_q   <= sel_header;
        data_q     <= sel_has_data ? sel_data : '0;
        has_data_q <= sel_has_data;
        ptr        <= ptr_next;
      end

      if (state == LOAD) begin
        hv_q <= 1'b1;
        dv_q <= has_data_q;
      end

      if (wd_clear) begin
        wd_cnt <= '0;
      end else if (wd_inc) begin
        wd_cnt <= wd_cnt + 8'd1;
      end

      if ((state == GAP) && (state_next == GAP)) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign o_grant        = grant_q;
  assign o_header       = header_q;
  assign o_data         = data_q;
  assign o_header_valid = hv_q;
  assign o_data_valid   = dv_q;
  assign o_ser_timeout  = timeout_q;
  assign o_busy         = (state != IDLE);

endmodule
